// File: rtl/buf_col_ctrl_pkg.sv
// buf_col_ctrl_pkg: shared state encoding and widths for the column-buffer rotation controller.
`default_nettype none

package buf_col_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_SLIDE = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  localparam int SEL_W   = 2;
  localparam int STALL_W = 16;

endpackage

`default_nettype wire

// File: rtl/buf_col_mod_counter.sv
// buf_col_mod_counter: modulo-N enable counter; WRAP flags the terminal count N-1.
`default_nettype none

module buf_col_mod_counter
  import buf_col_ctrl_pkg::*;
#(
  parameter int N = 4,
  parameter int W = SEL_W
) (
  input  logic         CLK,
  input  logic         RST_ASYNC_N,
  input  logic         EN,
  output logic [W-1:0] CNT,
  output logic         WRAP
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    WRAP  = (cnt_q == LAST);
    cnt_d = cnt_q;
    if (EN) begin
      cnt_d = WRAP ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign CNT = cnt_q;

endmodule

`default_nettype wire

// File: rtl/buf_col_ctrl.sv
// buf_col_ctrl: column-buffer rotation controller for the sliding-window datapath.
// Optional stall counter on STALL_CNT when BUF_COL_CTRL_STALL_CNT_EN is defined.
`default_nettype none

module buf_col_ctrl
  import buf_col_ctrl_pkg::*;
#(
  parameter int IMG_ROWS   = 8,
  parameter int IMG_COLS   = 8,
  parameter int N_BUF_COLS = 3
) (
  input  logic                        CLK,
  input  logic                        RST_ASYNC_N,
  input  logic                        START,
  input  logic                        PIX_VALID,
  output logic                        PIX_READY,
  output logic                        BUF_WR_EN,
  output logic [$clog2(IMG_ROWS)-1:0] BUF_ROW_ADDR,
  output logic                        SEL_WRITE_EN,
  output logic [SEL_W-1:0]            SEL_DATA,
  output logic                        WINDOW_VALID,
  output logic                        BUSY,
`ifdef BUF_COL_CTRL_STALL_CNT_EN
  output logic [STALL_W-1:0]          STALL_CNT,
`endif
  output logic                        DONE
);

  localparam int ROW_W = $clog2(IMG_ROWS);
  localparam int COL_W = $clog2(IMG_COLS + 1);

  state_e             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               sel_we_q, sel_we_d;
  logic               win_q, win_d;
  logic               pix_ready, accept, row_wrap, col_done;
  logic [ROW_W-1:0]   row_cnt;
  logic [SEL_W-1:0]   cur_sel;
  logic               sel_wrap_unused;

  assign pix_ready = (state_q == ST_FILL) || (state_q == ST_SLIDE);
  assign accept    = PIX_VALID && pix_ready;
  assign col_done  = accept && row_wrap;

  buf_col_mod_counter #(.N(IMG_ROWS), .W(ROW_W)) u_row_cnt (
    .CLK         (CLK),
    .RST_ASYNC_N (RST_ASYNC_N),
    .EN          (accept),
    .CNT         (row_cnt),
    .WRAP        (row_wrap)
  );

  // cur_sel updates on the same edge as the select strobe, so it doubles as the held SEL_DATA register.
  buf_col_mod_counter #(.N(N_BUF_COLS), .W(SEL_W)) u_sel_cnt (
    .CLK         (CLK),
    .RST_ASYNC_N (RST_ASYNC_N),
    .EN          (col_done),
    .CNT         (cur_sel),
    .WRAP        (sel_wrap_unused)
  );

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    sel_we_d = 1'b0;
    win_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_FILL;
          col_d   = '0;
        end
      end
      ST_FILL, ST_SLIDE: begin
        if (col_done) begin
          col_d    = col_q + COL_W'(1);
          sel_we_d = 1'b1;
          win_d    = (col_q >= COL_W'(N_BUF_COLS - 1));
          if (col_q == COL_W'(IMG_COLS - 1)) begin
            state_d = ST_FIN;
          end else if ((state_q == ST_FILL) && (col_q == COL_W'(N_BUF_COLS - 1))) begin
            state_d = ST_SLIDE;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      state_q  <= ST_IDLE;
      col_q    <= '0;
      sel_we_q <= 1'b0;
      win_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      sel_we_q <= sel_we_d;
      win_q    <= win_d;
    end
  end

`ifdef BUF_COL_CTRL_STALL_CNT_EN
  logic [STALL_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == ST_IDLE) && START) begin
      stall_d = '0;
    end else if (pix_ready && !PIX_VALID && (stall_q != '1)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign STALL_CNT = stall_q;
`endif

  assign PIX_READY    = pix_ready;
  assign BUF_WR_EN    = accept;
  assign BUF_ROW_ADDR = row_cnt;
  assign SEL_WRITE_EN = sel_we_q;
  assign SEL_DATA     = cur_sel;
  assign WINDOW_VALID = win_q;
  assign BUSY         = (state_q != ST_IDLE);
  assign DONE         = (state_q == ST_FIN);

endmodule

`default_nettype wire

// File: tb/tb_buf_col_ctrl.sv
// tb_buf_col_ctrl: three parameterisations driven by shared random stimulus, checked against a frame-level model.
`default_nettype none

module tb_buf_col_ctrl;

  logic CLK = 1'b0;
  logic RST_ASYNC_N, START, PIX_VALID;

  logic       pr[3], wr[3], swe[3], win[3], busy[3], done[3];
  logic [1:0] sd[3];
  logic [2:0] a0, a1;
  logic [0:0] a2;
`ifdef BUF_COL_CTRL_STALL_CNT_EN
  logic [15:0] sc[3];
`endif

  int R[3]  = '{8, 8, 2};
  int C[3]  = '{8, 6, 4};
  int NB[3] = '{3, 4, 2};

  // Model state: phase 0 idle / 1 streaming / 2 finishing, accepts this frame, columns ever completed.
  int ph[3], acc[3], cols_tot[3], e_we[3], e_data[3], e_win[3], stl[3];
  int n_vec = 0, n_err = 0, n_done_seen = 0;
  int did_mid = 0, rst_hold = 0;

  always #5 CLK = ~CLK;

  buf_col_ctrl #(.IMG_ROWS(8), .IMG_COLS(8), .N_BUF_COLS(3)) u0 (
    .CLK(CLK), .RST_ASYNC_N(RST_ASYNC_N), .START(START), .PIX_VALID(PIX_VALID),
    .PIX_READY(pr[0]), .BUF_WR_EN(wr[0]), .BUF_ROW_ADDR(a0), .SEL_WRITE_EN(swe[0]),
    .SEL_DATA(sd[0]), .WINDOW_VALID(win[0]), .BUSY(busy[0]),
`ifdef BUF_COL_CTRL_STALL_CNT_EN
    .STALL_CNT(sc[0]),
`endif
    .DONE(done[0]));

  buf_col_ctrl #(.IMG_ROWS(8), .IMG_COLS(6), .N_BUF_COLS(4)) u1 (
    .CLK(CLK), .RST_ASYNC_N(RST_ASYNC_N), .START(START), .PIX_VALID(PIX_VALID),
    .PIX_READY(pr[1]), .BUF_WR_EN(wr[1]), .BUF_ROW_ADDR(a1), .SEL_WRITE_EN(swe[1]),
    .SEL_DATA(sd[1]), .WINDOW_VALID(win[1]), .BUSY(busy[1]),
`ifdef BUF_COL_CTRL_STALL_CNT_EN
    .STALL_CNT(sc[1]),
`endif
    .DONE(done[1]));

  buf_col_ctrl #(.IMG_ROWS(2), .IMG_COLS(4), .N_BUF_COLS(2)) u2 (
    .CLK(CLK), .RST_ASYNC_N(RST_ASYNC_N), .START(START), .PIX_VALID(PIX_VALID),
    .PIX_READY(pr[2]), .BUF_WR_EN(wr[2]), .BUF_ROW_ADDR(a2), .SEL_WRITE_EN(swe[2]),
    .SEL_DATA(sd[2]), .WINDOW_VALID(win[2]), .BUSY(busy[2]),
`ifdef BUF_COL_CTRL_STALL_CNT_EN
    .STALL_CNT(sc[2]),
`endif
    .DONE(done[2]));

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] at %0t: got %0d, want %0d", tag, i, $time, obs, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input int i);
    case (i)
      0:       return 32'(a0);
      1:       return 32'(a1);
      default: return 32'(a2);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      ph[i] = 0; acc[i] = 0; cols_tot[i] = 0;
      e_we[i] = 0; e_data[i] = 0; e_win[i] = 0; stl[i] = 0;
    end
  endtask

  task automatic model_step();
    int col;
    for (int i = 0; i < 3; i++) begin
      e_we[i]  = 0;
      e_win[i] = 0;
      case (ph[i])
        0: if (START) begin ph[i] = 1; acc[i] = 0; stl[i] = 0; end
        1: begin
          if (PIX_VALID) begin
            acc[i]++;
            if (acc[i] % R[i] == 0) begin
              col         = acc[i] / R[i] - 1;
              cols_tot[i] = cols_tot[i] + 1;
              e_we[i]     = 1;
              e_data[i]   = cols_tot[i] % NB[i];
              e_win[i]    = (col >= NB[i] - 1) ? 1 : 0;
              if (col == C[i] - 1) ph[i] = 2;
            end
          end else if (stl[i] < 65535) begin
            stl[i]++;
          end
        end
        default: ph[i] = 0;
      endcase
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk("pix_ready", i, 32'(pr[i]), 32'(ph[i] == 1));
      chk("busy", i, 32'(busy[i]), 32'(ph[i] != 0));
      chk("done", i, 32'(done[i]), 32'(ph[i] == 2));
      chk("buf_wr_en", i, 32'(wr[i]), 32'((ph[i] == 1) && PIX_VALID));
      if (ph[i] == 1) chk("row_addr", i, addr_of(i), 32'(acc[i] % R[i]));
      chk("sel_we", i, 32'(swe[i]), 32'(e_we[i]));
      chk("sel_data", i, 32'(sd[i]), 32'(e_data[i]));
      chk("window_valid", i, 32'(win[i]), 32'(e_win[i]));
`ifdef BUF_COL_CTRL_STALL_CNT_EN
      chk("stall_cnt", i, 32'(sc[i]), 32'(stl[i]));
`endif
      if (done[i] === 1'b1) n_done_seen++;
    end
  endtask

  initial begin
    RST_ASYNC_N = 1'b0;
    START       = 1'b0;
    PIX_VALID   = 1'b1;
    model_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge CLK);
      if (cyc == 4) RST_ASYNC_N = 1'b1;
      // Abort the first default-geometry frame at column 3, row 5.
      if (did_mid == 0 && RST_ASYNC_N && ph[0] == 1 && acc[0] == 29) begin
        RST_ASYNC_N = 1'b0;
        did_mid     = 1;
        rst_hold    = 2;
      end else if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) RST_ASYNC_N = 1'b1;
      end
      if (!RST_ASYNC_N) model_reset();
      START     = ($urandom_range(0, 99) < 40);
      PIX_VALID = (cyc < 400) ? 1'b1 : ($urandom_range(0, 99) >= 30);
      #1;
      check_all();
      @(posedge CLK);
      if (RST_ASYNC_N) model_step();
    end
    chk("mid_reset_hit", 0, 32'(did_mid), 32'd1);
    chk("frames_completed", 0, 32'(n_done_seen > 10), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
